rom_load_sequencer: RTL

//  Sits between hps_io's ioctl download port and the bagman core.

---
 rtl/rom_load_sequencer.sv | 181 ++++++++++++++++++
 1 files changed

// File: rtl/rom_load_sequencer.sv
// ROM download decoder and core-reset sequencer between hps_io ioctl and the bagman core.
// Optional build macro ROM_CHECKSUM_EN adds a mod-256 image checksum to the load verdict.
//
// state | meaning
// IDLE  | no image loaded yet, core held in reset
// LOAD  | download in progress, writes decoded to region strobes
// HOLD  | settle period after a download or soft reset, core held in reset
// RUN   | core released
module rom_load_sequencer #(
   parameter logic [16:0] CPU_END     = 17'h06000,
   parameter logic [16:0] GFX_END     = 17'h0A000,
   parameter logic [16:0] PROM_END    = 17'h0A040,
   parameter logic [16:0] SND_END     = 17'h0C040,
   parameter int          HOLD_CYCLES = 1024
`ifdef ROM_CHECKSUM_EN
   , parameter logic [7:0] EXPECTED_SUM = 8'h00
`endif
) (
   input  logic        clk_sys,
   input  logic        reset_n,
   input  logic        ioctl_download,
   input  logic        ioctl_wr,
   input  logic [24:0] ioctl_addr,
   input  logic [7:0]  ioctl_dout,
   input  logic        soft_reset,
   output logic [16:0] dn_addr,
   output logic [7:0]  dn_data,
   output logic        cpu_we,
   output logic        gfx_we,
   output logic        prom_we,
   output logic        snd_we,
   output logic        game_reset,
   output logic        load_ok,
   output logic        load_err,
   output logic [16:0] byte_count,
   output logic [7:0]  rom_sum
);

   localparam int CW = (HOLD_CYCLES > 2) ? $clog2(HOLD_CYCLES) : 1;
   localparam logic [CW-1:0] HOLD_LAST = (HOLD_CYCLES > 1) ? CW'(HOLD_CYCLES - 1) : '0;

   localparam logic [24:0] CPU_END_W  = {8'd0, CPU_END};
   localparam logic [24:0] GFX_END_W  = {8'd0, GFX_END};
   localparam logic [24:0] PROM_END_W = {8'd0, PROM_END};
   localparam logic [24:0] SND_END_W  = {8'd0, SND_END};

   typedef enum logic [1:0] {IDLE, LOAD, HOLD, RUN} state_t;

   state_t        state;
   logic          dl_q;
   logic          overflow;
   logic          verdict_pend;
   logic [CW-1:0] hold_cnt;
   logic          dl_rise;
   logic          dl_fall;
   logic          load_start;
   logic          wr_ok;
   logic          addr_over;
   logic [3:0]    region;
   logic          sum_ok;
   logic          image_ok;

   assign dl_rise    = ioctl_download & ~dl_q;
   assign dl_fall    = ~ioctl_download & dl_q;
   assign load_start = dl_rise & ((state == IDLE) | (state == RUN));
   assign wr_ok      = ioctl_wr & (state == LOAD);
   assign addr_over  = (ioctl_addr >= SND_END_W);
   assign image_ok   = (byte_count == SND_END) & ~overflow & sum_ok;

   always_comb begin
      region = 4'b0000;
      if (ioctl_addr < CPU_END_W)
         region = 4'b1000;
      else if (ioctl_addr < GFX_END_W)
         region = 4'b0100;
      else if (ioctl_addr < PROM_END_W)
         region = 4'b0010;
      else if (ioctl_addr < SND_END_W)
         region = 4'b0001;
   end

   // Tracks the input even through reset so a download still high at release is not a fresh rise.
   always_ff @(posedge clk_sys) begin
      dl_q <= ioctl_download;
   end

   always_ff @(posedge clk_sys) begin
      if (!reset_n) begin
         state        <= IDLE;
         game_reset   <= 1'b1;
         cpu_we       <= 1'b0;
         gfx_we       <= 1'b0;
         prom_we      <= 1'b0;
         snd_we       <= 1'b0;
         dn_addr      <= '0;
         dn_data      <= '0;
         byte_count   <= '0;
         load_ok      <= 1'b0;
         load_err     <= 1'b0;
         overflow     <= 1'b0;
         verdict_pend <= 1'b0;
         hold_cnt     <= '0;
      end else begin
         cpu_we       <= wr_ok & region[3];
         gfx_we       <= wr_ok & region[2];
         prom_we      <= wr_ok & region[1];
         snd_we       <= wr_ok & region[0];
         verdict_pend <= 1'b0;
         game_reset   <= (state != RUN);

         if (wr_ok) begin
            dn_addr <= ioctl_addr[16:0];
            dn_data <= ioctl_dout;
            if (byte_count != '1)
               byte_count <= byte_count + 17'd1;
            if (addr_over)
               overflow <= 1'b1;
         end

         if (verdict_pend) begin
            load_ok  <= image_ok;
            load_err <= ~image_ok;
         end

         if (load_start) begin
            byte_count <= '0;
            overflow   <= 1'b0;
            load_ok    <= 1'b0;
            load_err   <= 1'b0;
         end

         case (state)
            IDLE: begin
               if (load_start)
                  state <= LOAD;
            end
            LOAD: begin
               if (dl_fall) begin
                  state        <= HOLD;
                  hold_cnt     <= '0;
                  verdict_pend <= 1'b1;
               end
            end
            HOLD: begin
               if (soft_reset)
                  hold_cnt <= '0;
               else if (hold_cnt == HOLD_LAST)
                  state <= RUN;
               else
                  hold_cnt <= hold_cnt + 1'b1;
            end
            RUN: begin
               if (load_start) begin
                  state <= LOAD;
               end else if (soft_reset) begin
                  state    <= HOLD;
                  hold_cnt <= '0;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

`ifdef ROM_CHECKSUM_EN
   always_ff @(posedge clk_sys) begin
      if (!reset_n)
         rom_sum <= '0;
      else if (load_start)
         rom_sum <= '0;
      else if (wr_ok)
         rom_sum <= rom_sum + ioctl_dout;
   end

   assign sum_ok = (rom_sum == EXPECTED_SUM);
`else
   assign rom_sum = 8'h00;
   assign sum_ok  = 1'b1;
`endif

endmodule
